// File: rtl/bcomp_trace_buffer.sv
// Change-triggered trace capture of a 39-bit controller word into a
// timestamped FIFO with drop accounting and synchronous flush.
module bcomp_trace_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      capture_en,
  input  logic [38:0]               ctrl_word,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [TS_W+38:0]          rd_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic [7:0]                drop_cnt,
  output logic                      overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW:0] lvl_t;
  localparam lvl_t FULL = lvl_t'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t           state;
  logic [TS_W-1:0]  ts;
  logic [38:0]      last_word;
  logic [TS_W+38:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             cap_req;
  logic             pop;
  logic             push;
  logic             drop;

  always_comb begin
    cap_req = 1'b0;
    if (!clr && capture_en) begin
      case (state)
        ARM:     cap_req = 1'b1;
        RUN:     cap_req = (ctrl_word != last_word);
        default: cap_req = 1'b0;
      endcase
    end
    pop  = rd_valid && rd_ready && !clr;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push = cap_req && ((level != FULL) || pop);
    drop = cap_req && !push;
  end

  assign rd_valid = (level != '0);
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (clr || !capture_en) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= ARM;
        ARM:     state <= RUN;
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts        <= '0;
      last_word <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      ts       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (cap_req) last_word <= ctrl_word;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ts, ctrl_word};
  end

endmodule

// File: tb/tb_bcomp_trace_buffer.sv
// Directed bench for bcomp_trace_buffer: inputs change and outputs are
// checked on the falling edge; each rising edge is one DUT cycle.
module tb_bcomp_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        capture_en;
  logic [38:0] ctrl_word;
  logic        rd_valid;
  logic        rd_ready;
  logic [54:0] rd_data;
  logic [3:0]  level;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  bcomp_trace_buffer #(.DEPTH(8), .TS_W(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .capture_en(capture_en),
    .ctrl_word(ctrl_word), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .level(level), .drop_cnt(drop_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ent(input int unsigned t, input logic [38:0] w);
    logic [15:0] t16;
    t16 = t[15:0];
    return 64'({t16, w});
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; capture_en = 1'b0; ctrl_word = '0; rd_ready = 1'b0;
    tick(); tick();
    check("rst_level", 64'(level), 64'd0);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;

    // Arm: edges see ts=0..3 idle, ts=4 enters ARM, ts=5 captures {5,0}
    repeat (4) tick();
    capture_en = 1'b1;
    tick();
    check("arm_no_entry", 64'(level), 64'd0);
    tick();
    check("arm_level", 64'(level), 64'd1);
    check("arm_valid", 64'(rd_valid), 64'd1);
    check("arm_data", 64'(rd_data), ent(5, 39'd0));

    // Change detection: 6 captured once at ts=6, held through ts=7,8
    ctrl_word = 39'h00_0000_0006;
    tick();
    check("chg_first", 64'(level), 64'd2);
    tick(); tick();
    check("chg_held", 64'(level), 64'd2);
    ctrl_word = 39'h40_0000_0000;
    tick();
    check("chg_new", 64'(level), 64'd3);
    check("chg_head", 64'(rd_data), ent(5, 39'd0));
    rd_ready = 1'b1;
    tick();
    check("drain_1", 64'(rd_data), ent(6, 39'h6));
    tick();
    check("drain_2", 64'(rd_data), ent(9, 39'h40_0000_0000));
    tick();
    check("drain_empty", 64'(rd_valid), 64'd0);
    check("drain_level", 64'(level), 64'd0);
    rd_ready = 1'b0;

    // Overflow: words 1..10 at ts=13..22; words 9 and 10 are dropped
    for (int i = 0; i < 10; i++) begin
      ctrl_word = 39'(i + 1);
      tick();
    end
    check("ovf_level", 64'(level), 64'd8);
    check("ovf_drop", 64'(drop_cnt), 64'd2);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_head", 64'(rd_data), ent(13, 39'd1));

    // Full with concurrent pop at ts=23
    ctrl_word = 39'h55;
    rd_ready = 1'b1;
    tick();
    check("fullpop_level", 64'(level), 64'd8);
    check("fullpop_drop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 7; i++) begin
      check("order", 64'(rd_data), ent(14 + i, 39'(i + 2)));
      tick();
    end
    check("order_last", 64'(rd_data), ent(23, 39'h55));
    tick();
    check("order_empty", 64'(level), 64'd0);

    // Clear priority: one entry at ts=32, then clr with pop and new word
    rd_ready = 1'b0;
    ctrl_word = 39'h77;
    tick();
    check("pre_clr_level", 64'(level), 64'd1);
    clr = 1'b1; rd_ready = 1'b1; ctrl_word = 39'h88;
    tick();
    clr = 1'b0; rd_ready = 1'b0;
    check("clr_level", 64'(level), 64'd0);
    check("clr_valid", 64'(rd_valid), 64'd0);
    check("clr_drop", 64'(drop_cnt), 64'd0);
    check("clr_ovf", 64'(overflow), 64'd0);
    // FSM left in IDLE and ts=0: ARM at ts=0, capture at ts=1
    tick();
    check("clr_idle", 64'(level), 64'd0);
    tick();
    check("clr_rearm", 64'(level), 64'd1);
    check("clr_ts", 64'(rd_data), ent(1, 39'h88));

    // Async reset mid-stream with five entries
    for (int i = 0; i < 4; i++) begin
      ctrl_word = 39'(32'h91 + i);
      tick();
    end
    check("pre_rst_level", 64'(level), 64'd5);
    #2 rst = 1'b1;
    #1;
    check("async_level", 64'(level), 64'd0);
    check("async_valid", 64'(rd_valid), 64'd0);
    tick();
    rst = 1'b0;
    ctrl_word = 39'h1234;
    tick();
    check("post_rst_arm", 64'(level), 64'd0);
    tick();
    check("post_rst_cap", 64'(level), 64'd1);
    check("post_rst_data", 64'(rd_data), ent(1, 39'h1234));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcomp_trace_buffer.md
BCOMP_TRACE_BUFFER -- requirements
Module: bcomp_trace_buffer

Interface
REQ-001 Parameter DEPTH, 8, number of FIFO entries; a power of two from 2 to 64.
REQ-002 Parameter TS_W, 16, timestamp width in bits.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous flush; takes effect on the next rising edge.
REQ-006 capture_en  input  1  enables capture of the control word.
REQ-007 ctrl_word  input  39  controller outputs y39..y1, with y1 at bit 0; upstream updates it on the falling edge, so it is stable at the rising edge.
REQ-008 rd_valid  output  1  the head FIFO entry is available.
REQ-009 rd_ready  input  1  the consumer accepts the head entry.
REQ-010 rd_data  output  TS_W+39  head entry, {timestamp, ctrl_word}.
REQ-011 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 drop_cnt  output  8  count of dropped captures; saturates at 255.
REQ-013 overflow  output  1  sticky flag, set by the first dropped capture.

Function
REQ-014 The block SHALL contain a free-running TS_W-bit timestamp counter that increments every cycle and wraps from all-ones to 0.
REQ-015 The capture FSM SHALL have three states:
- IDLE: no capture.
- ARM: the first sample is always captured.
- RUN: a sample is captured only when ctrl_word differs from the last captured word.
REQ-016 The FSM SHALL follow these transitions:
- IDLE->ARM when capture_en=1.
- ARM->RUN unconditionally after one cycle.
- ARM or RUN -> IDLE whenever capture_en=0.
REQ-017 A capture request SHALL latch {timestamp, ctrl_word} as sampled at the same rising edge, with the timestamp value before its increment.
REQ-018 The last-captured-word register SHALL update on every capture request, whether the request is accepted or dropped.
REQ-019 A capture request SHALL be accepted if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
REQ-020 A capture request that is not accepted SHALL be dropped, set overflow, and increment drop_cnt by 1 (saturating at 255).
REQ-021 A pop SHALL occur exactly when rd_valid=1 and rd_ready=1.
REQ-022 rd_valid SHALL equal (level!=0).
REQ-023 rd_data SHALL present the head entry combinationally from storage and hold it stable while rd_valid=1 and rd_ready=0.
REQ-024 Push-to-visible latency SHALL be one cycle: an entry written at edge N is on rd_data with rd_valid=1 after edge N.
REQ-025 When push and pop occur in the same cycle, level SHALL stay unchanged and FIFO order SHALL be preserved.
REQ-026 When level==0, a pop SHALL be impossible; a push into an empty FIFO SHALL NOT bypass storage.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 clr=1 SHALL:
- empty the FIFO (level=0);
- zero drop_cnt, overflow and the timestamp;
- force the FSM to IDLE;
- block any capture and any pop in that cycle.
REQ-029 clr SHALL have priority over capture_en, rd_ready and ctrl_word changes.
REQ-030 When capture_en falls in the middle of a run, FIFO contents SHALL be retained and draining SHALL continue.

Reset
REQ-031 While rst=1, the block SHALL hold:
- FSM=IDLE;
- timestamp=0;
- last captured word=0;
- pointers=0 and level=0;
- rd_valid=0;
- drop_cnt=0 and overflow=0.
REQ-032 FIFO storage contents SHALL be don't-care after reset, and rd_data SHALL NOT be checked while rd_valid=0.
REQ-033 Assertion of rst mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-034 After rst deasserts, the first capture SHALL occur only after the FSM has passed through ARM.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Arm capture: rst pulse; capture_en=1 at ts=5 with ctrl_word=0 -> one entry {5, 0}; level=1; rd_valid=1 one cycle after the push.
- Change detection: hold ctrl_word=0x000_0000_0006 for 3 cycles, then change it to 0x40_0000_0000 -> exactly one new entry per distinct value; no entry while the value is held.
- Overflow: DEPTH=8 with rd_ready=0 and 10 distinct words -> level=8, drop_cnt=2, overflow=1; entries 1-8 read back in order.
- Full with concurrent pop: level=8, rd_ready=1 and a new distinct word -> accepted; level stays 8; drop_cnt unchanged.
- Clear priority: clr=1 with rd_ready=1 and a new word -> next cycle level=0, rd_valid=0, drop_cnt=0, overflow=0, timestamp=0.
- Async reset mid-stream: rst asserted between clock edges while level=5 -> level=0 and rd_valid=0 before the next edge.
